ball_motion_controller: RTL and testbench
=========================================

// Module: ball_motion_controller
// PURPOSE
//  Owns the ball: holds ballX/ballY, steps them one pixel per axis on each frameTick, and
//  reflects on collision flags from the paddle/floor collision stage (one instance per paddle).
//  Feeds ballX/ballY back into those stages and to the renderer; reports misses to scoring.
//  Coordinates are y-up: floor at FLOOR_Y (bottom), ceiling at CEIL_Y.
// PARAMETERS
//  BIT_WIDTH    10   coordinate width (unsigned)
//  SCREEN_W     640  playfield width; legal ballX range 0..SCREEN_W-1
//  FLOOR_Y      0    floor line; must match the collision stage
//  CEIL_Y       479  ceiling line
//  BALL_RADIUS  4    ball radius in pixels
//  START_X      320  serve position X
//  START_Y      240  serve position Y
//  SERVE_DELAY  60   frameTicks between serve request and ball release (>=1)
// PORTS
//  clk                 in   1          system clock
//  reset               in   1          synchronous, active-high
//  frameTick           in   1          one-cycle pulse per frame; ball advances only on it
//  serveBtn            in   1          level; starts a serve from IDLE
//  ballTouchingPaddleL in   1          from left-paddle collision instance
//  ballTouchingPaddleR in   1          from right-paddle collision instance
//  ballTouchingFloor   in   1          from collision stage (either instance, ORed upstream)
//  ballX               out  BIT_WIDTH  ball centre X (registered)
//  ballY               out  BIT_WIDTH  ball centre Y (registered)
//  inPlay              out  1          1 while state==PLAY
//  missLeft            out  1          one-cycle pulse: ball passed left edge
//  missRight           out  1          one-cycle pulse: ball passed right edge
// BEHAVIOUR
//  Reset: state=IDLE, ballX=START_X, ballY=START_Y, dirX=+1, dirY=+1, serveCnt=0, all pulses 0.
//  FSM: IDLE -serveBtn-> SERVE_WAIT -(serveCnt==SERVE_DELAY-1 on tick)-> PLAY -miss-> MISS -> IDLE.
//   IDLE: ball parked at START; serveCnt=0.
//   SERVE_WAIT: serveCnt increments per frameTick; ball stays parked; serveBtn ignored.
//   PLAY, on frameTick only (inputs sampled that cycle; new ballX/ballY visible next cycle):
//    1 paddle: if L or R touching: dirX = (ballX < SCREEN_W/2) ? +1 : -1 (idempotent, no re-flip).
//    2 floor: if ballTouchingFloor: dirY=+1. ceiling: if ballY+BALL_RADIUS >= CEIL_Y: dirY=-1.
//    3 miss (only if no paddle touch this tick): ballX <= BALL_RADIUS -> missLeft;
//      ballX >= SCREEN_W-1-BALL_RADIUS -> missRight; ball does not move, go MISS.
//    4 else ballX += dirX, ballY += dirY using the directions updated in 1-2.
//   MISS: one cycle; missLeft/missRight high exactly this cycle; ball reset to START;
//     next serve dirX points toward the side that missed; dirY=+1; -> IDLE.
//  Paddle and floor on the same tick: both applied. Paddle touch overrides edge miss.
//  Step is exactly 1 pixel/axis/tick: collision stage uses equality tests; larger steps forbidden.
//  frameTick outside PLAY/SERVE_WAIT has no effect. Reset mid-play returns to reset values next edge.
//  Arithmetic: BIT_WIDTH+1 internal for +/- to detect wrap; positions never wrap in practice.
// CONFIGURATION
//  BALL_MOTION_SCORE_EN defined: adds outputs scoreLeft/scoreRight [3:0]; missRight increments
//   scoreLeft, missLeft increments scoreRight, saturating at 15; both cleared by reset only.
//  Undefined: ports and counters absent; miss pulses are the only scoring interface.
// TESTING (SERVE_DELAY=4 for bench)
//  Reset, 3 ticks, no serve -> ballX=320, ballY=240, inPlay=0, pulses 0.
//  serveBtn, 4 ticks -> inPlay=1; 5th tick -> next cycle ballX=321, ballY=241.
//  PLAY at (600,100) dirX=+1, pulse PaddleR with tick -> ballX=599; further ticks keep decreasing.
//  At ballY=4 dirY=-1, Floor=1 with tick -> ballY=5; same tick with PaddleL at ballX=20 -> (21,5).
//  Ball at ballX=4 dirX=-1, tick, no paddle -> missLeft one cycle, ball (320,240), IDLE, next serve dirX=-1.
//  With BALL_MOTION_SCORE_EN: 16 missRight events -> scoreLeft saturates at 15; reset -> 0.

Source files
------------

// File: rtl/ball_motion_controller.sv
`timescale 1ns/1ps
// Ball position/direction controller: serve, per-frame motion, reflection and miss detection.
// Optional build macro BALL_MOTION_SCORE_EN adds saturating scoreLeft/scoreRight counters.
module ball_motion_controller #(
    parameter int unsigned BIT_WIDTH   = 10,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned FLOOR_Y     = 0,
    parameter int unsigned CEIL_Y      = 479,
    parameter int unsigned BALL_RADIUS = 4,
    parameter int unsigned START_X     = 320,
    parameter int unsigned START_Y     = 240,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frameTick,
    input  logic                 serveBtn,
    input  logic                 ballTouchingPaddleL,
    input  logic                 ballTouchingPaddleR,
    input  logic                 ballTouchingFloor,
    output logic [BIT_WIDTH-1:0] ballX,
    output logic [BIT_WIDTH-1:0] ballY,
    output logic                 inPlay,
    output logic                 missLeft,
`ifdef BALL_MOTION_SCORE_EN
    output logic                 missRight,
    output logic [3:0]           scoreLeft,
    output logic [3:0]           scoreRight
`else
    output logic                 missRight
`endif
);

    localparam int unsigned XW    = BIT_WIDTH + 1;
    localparam int unsigned CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [BIT_WIDTH-1:0] START_XV   = BIT_WIDTH'(START_X);
    localparam logic [BIT_WIDTH-1:0] START_YV   = BIT_WIDTH'(START_Y);
    localparam logic [XW-1:0]        HALF_W     = XW'(SCREEN_W / 2);
    localparam logic [XW-1:0]        RADIUS     = XW'(BALL_RADIUS);
    localparam logic [XW-1:0]        CEIL_E     = XW'(CEIL_Y);
    localparam logic [XW-1:0]        FLOOR_E    = XW'(FLOOR_Y);
    localparam logic [XW-1:0]        RIGHT_EDGE = XW'(SCREEN_W - 1 - BALL_RADIUS);
    localparam logic [CNT_W-1:0]     SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SERVE_WAIT = 2'd1,
        S_PLAY       = 2'd2,
        S_MISS       = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] x_q, x_d;
    logic [BIT_WIDTH-1:0] y_q, y_d;
    logic                 dir_x_q, dir_x_d;    // 1 = moving toward +X
    logic                 dir_y_q, dir_y_d;    // 1 = moving toward +Y (up)
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_play_q, in_play_d;
    logic                 miss_left_q, miss_left_d;
    logic                 miss_right_q, miss_right_d;
`ifdef BALL_MOTION_SCORE_EN
    logic [3:0]           score_left_q, score_left_d;
    logic [3:0]           score_right_q, score_right_d;
`endif

    logic [XW-1:0] ext_x;
    logic [XW-1:0] ext_y;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] sum_y;
    logic          touch;

    // Next-state, motion and reflection logic.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        cnt_d        = cnt_q;
        miss_left_d  = 1'b0;
        miss_right_d = 1'b0;
        ext_x        = {1'b0, x_q};
        ext_y        = {1'b0, y_q};
        sum_x        = ext_x;
        sum_y        = ext_y;
        touch        = ballTouchingPaddleL | ballTouchingPaddleR;
`ifdef BALL_MOTION_SCORE_EN
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                x_d   = START_XV;
                y_d   = START_YV;
                cnt_d = '0;
                if (serveBtn) begin
                    state_d = S_SERVE_WAIT;
                end
            end

            S_SERVE_WAIT: begin
                if (frameTick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_PLAY: begin
                if (frameTick) begin
                    if (touch) begin
                        dir_x_d = (ext_x < HALF_W);
                    end
                    if (ballTouchingFloor) begin
                        dir_y_d = 1'b1;
                    end
                    if ((ext_y + RADIUS) >= CEIL_E) begin
                        dir_y_d = 1'b0;
                    end

                    if (!touch && (ext_x <= RADIUS)) begin
                        miss_left_d = 1'b1;
                        state_d     = S_MISS;
                    end else if (!touch && (ext_x >= RIGHT_EDGE)) begin
                        miss_right_d = 1'b1;
                        state_d      = S_MISS;
                    end else begin
                        sum_x = dir_x_d ? (ext_x + XW'(1)) : (ext_x - XW'(1));
                        sum_y = dir_y_d ? (ext_y + XW'(1)) : (ext_y - XW'(1));
                        // Hold an axis rather than wrap or sink below the floor line.
                        x_d = sum_x[XW-1] ? x_q : sum_x[BIT_WIDTH-1:0];
                        y_d = ($signed(sum_y) < $signed(FLOOR_E)) ? y_q : sum_y[BIT_WIDTH-1:0];
                    end
                end
            end

            S_MISS: begin
                x_d     = START_XV;
                y_d     = START_YV;
                dir_x_d = !miss_left_q;
                dir_y_d = 1'b1;
                state_d = S_IDLE;
`ifdef BALL_MOTION_SCORE_EN
                if (miss_right_q && (score_left_q != 4'd15)) begin
                    score_left_d = score_left_q + 4'd1;
                end
                if (miss_left_q && (score_right_q != 4'd15)) begin
                    score_right_d = score_right_q + 4'd1;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_play_d = (state_d == S_PLAY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= START_XV;
            y_q          <= START_YV;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            cnt_q        <= '0;
            in_play_q    <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
`ifdef BALL_MOTION_SCORE_EN
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            cnt_q        <= cnt_d;
            in_play_q    <= in_play_d;
            miss_left_q  <= miss_left_d;
            miss_right_q <= miss_right_d;
`ifdef BALL_MOTION_SCORE_EN
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
`endif
        end
    end

    assign ballX     = x_q;
    assign ballY     = y_q;
    assign inPlay    = in_play_q;
    assign missLeft  = miss_left_q;
    assign missRight = miss_right_q;
`ifdef BALL_MOTION_SCORE_EN
    assign scoreLeft  = score_left_q;
    assign scoreRight = score_right_q;
`endif

endmodule

// File: tb/tb_ball_motion_controller.sv
`timescale 1ns/1ps
// Self-checking bench for ball_motion_controller: directed game scenarios plus randomized
// play checked every cycle against an arithmetic reference model of the ball.
module tb_ball_motion_controller;

    localparam int SW   = 640;
    localparam int RAD  = 4;
    localparam int CEIL = 479;
    localparam int SX   = 320;
    localparam int SY   = 240;
    localparam int SD   = 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PLAY = 2;
    localparam int M_MISS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frameTick = 1'b0;
    logic       serveBtn = 1'b0;
    logic       ballTouchingPaddleL = 1'b0;
    logic       ballTouchingPaddleR = 1'b0;
    logic       ballTouchingFloor = 1'b0;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic       inPlay;
    logic       missLeft;
    logic       missRight;
`ifdef BALL_MOTION_SCORE_EN
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model of the game ball.
    int m_mode, mx, my, mdx, mdy, m_ticks;
    int m_ml, m_mr, m_sl, m_sr;

    ball_motion_controller #(
        .BIT_WIDTH  (10),
        .SCREEN_W   (SW),
        .FLOOR_Y    (0),
        .CEIL_Y     (CEIL),
        .BALL_RADIUS(RAD),
        .START_X    (SX),
        .START_Y    (SY),
        .SERVE_DELAY(SD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .frameTick          (frameTick),
        .serveBtn           (serveBtn),
        .ballTouchingPaddleL(ballTouchingPaddleL),
        .ballTouchingPaddleR(ballTouchingPaddleR),
        .ballTouchingFloor  (ballTouchingFloor),
        .ballX              (ballX),
        .ballY              (ballY),
        .inPlay             (inPlay),
        .missLeft           (missLeft),
`ifdef BALL_MOTION_SCORE_EN
        .missRight          (missRight),
        .scoreLeft          (scoreLeft),
        .scoreRight         (scoreRight)
`else
        .missRight          (missRight)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit sv,
                              input bit pl, input bit pr, input bit fl);
        int nl, nr;
        bit touch;
        nl = 0;
        nr = 0;
        if (rst) begin
            m_mode = M_IDLE; mx = SX; my = SY; mdx = 1; mdy = 1; m_ticks = 0;
            m_ml = 0; m_mr = 0; m_sl = 0; m_sr = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                mx = SX; my = SY; m_ticks = 0;
                if (sv) m_mode = M_WAIT;
            end
            M_WAIT: begin
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == SD) begin
                        m_ticks = 0;
                        m_mode = M_PLAY;
                    end
                end
            end
            M_PLAY: begin
                if (tk) begin
                    touch = pl | pr;
                    if (touch) mdx = (mx < SW / 2) ? 1 : -1;
                    if (fl) mdy = 1;
                    if (my + RAD >= CEIL) mdy = -1;
                    if (!touch && mx <= RAD) begin
                        nl = 1; m_mode = M_MISS;
                    end else if (!touch && mx >= SW - 1 - RAD) begin
                        nr = 1; m_mode = M_MISS;
                    end else begin
                        mx += mdx;
                        my += mdy;
                    end
                end
            end
            default: begin
                mx = SX; my = SY; mdy = 1;
                mdx = m_ml ? -1 : 1;
                if (m_mr && m_sl < 15) m_sl++;
                if (m_ml && m_sr < 15) m_sr++;
                m_mode = M_IDLE;
            end
        endcase
        m_ml = nl;
        m_mr = nr;
    endtask

    task automatic check_all();
        chk("ballX", ballX, mx);
        chk("ballY", ballY, my);
        chk("inPlay", inPlay, (m_mode == M_PLAY) ? 1 : 0);
        chk("missLeft", missLeft, m_ml);
        chk("missRight", missRight, m_mr);
`ifdef BALL_MOTION_SCORE_EN
        chk("scoreLeft", scoreLeft, m_sl);
        chk("scoreRight", scoreRight, m_sr);
`endif
    endtask

    task automatic step(input bit rst, input bit tk, input bit sv,
                        input bit pl, input bit pr, input bit fl);
        reset = rst;
        frameTick = tk;
        serveBtn = sv;
        ballTouchingPaddleL = pl;
        ballTouchingPaddleR = pr;
        ballTouchingFloor = fl;
        model_step(rst, tk, sv, pl, pr, fl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One frame: a tick cycle followed by a quiet cycle.
    task automatic frame(input bit pl, input bit pr, input bit fl);
        step(0, 1, 0, pl, pr, fl);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic serve_and_release();
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < SD; i++) frame(0, 0, 0);
        chk("serve_inplay", inPlay, 1);
    endtask

    // what: 0 = model X reaches target, 1 = model Y reaches target, 2 = a miss is taken.
    task automatic run_until(input int what, input int target, input int budget, input string tag);
        bit done;
        bit tk;
        bit fl;
        done = 0;
        for (int n = 0; n < 2 * budget && !done; n++) begin
            tk = (n % 2) == 0;
            fl = tk && (m_mode == M_PLAY) && (my <= RAD);
            step(0, tk, 0, 0, 0, fl);
            if (what == 0) done = (mx == target);
            else if (what == 1) done = (my == target);
            else done = (m_mode == M_MISS);
        end
        if (what == 0) chk(tag, ballX, target);
        else if (what == 1) chk(tag, ballY, target);
        else chk(tag, missLeft | missRight, 1);
    endtask

    initial begin
        int x0;
        bit rst, tk, sv, pl, pr, fl;

        // Reset and idle ticks leave the ball parked.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) frame(0, 0, 0);
        chk("idle_x", ballX, 320);
        chk("idle_y", ballY, 240);
        chk("idle_inplay", inPlay, 0);

        // Serve and first motion step.
        serve_and_release();
        frame(0, 0, 0);
        chk("first_x", ballX, 321);
        chk("first_y", ballY, 241);

        // Right paddle reflects an incoming ball.
        run_until(0, 600, 400, "reach_x600");
        frame(0, 1, 0);
        chk("paddle_r_x", ballX, 599);
        frame(0, 0, 0);
        frame(0, 0, 0);
        chk("keep_left_x", ballX, 597);

        // Floor and left paddle on the same tick.
        run_until(1, 4, 700, "reach_y4");
        x0 = mx;
        step(0, 1, 0, 1, 0, 1);
        chk("floor_y", ballY, 5);
        chk("paddle_l_x", ballX, x0 + 1);
        step(0, 0, 0, 0, 0, 0);

        // Ball exits on the right.
        run_until(2, 0, 700, "miss_right_seen");
        chk("miss_right_pulse", missRight, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("after_miss_r_x", ballX, 320);
        chk("after_miss_r_pulse", missRight, 0);

        // Reflect toward left, then miss on the left.
        serve_and_release();
        frame(0, 1, 0);
        chk("serve_reflect_x", ballX, 319);
        run_until(2, 0, 900, "miss_left_seen");
        chk("miss_left_pulse", missLeft, 1);
        chk("miss_left_inplay", inPlay, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("after_miss_l_x", ballX, 320);
        chk("after_miss_l_y", ballY, 240);
        chk("after_miss_l_pulse", missLeft, 0);
        serve_and_release();
        frame(0, 0, 0);
        chk("serve_dir_left_x", ballX, 319);
        chk("serve_dir_left_y", ballY, 241);

        // Randomized play including occasional mid-game resets.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            sv  = ($urandom_range(0, 7) == 0);
            pl  = ($urandom_range(0, 49) == 0);
            pr  = ($urandom_range(0, 49) == 0);
            fl  = ((m_mode == M_PLAY) && (my <= RAD)) || ($urandom_range(0, 29) == 0);
            step(rst, tk, sv, pl, pr, fl);
        end

        // Reset from an arbitrary state.
        step(1, 0, 0, 0, 0, 0);
        chk("final_reset_x", ballX, 320);
        chk("final_reset_y", ballY, 240);
        chk("final_reset_inplay", inPlay, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
